// File: rtl/mod_n_updown_counter.sv
// Modulo-N up/down counter with prescaler tick, parallel load, clear, wrap/saturate and terminal-count pulse.
// Q and LED update on the CLK edge where a clear, load or qualified tick occurs; TICK and TC are combinational.
module mod_n_updown_counter #(
  parameter int WIDTH    = 4,
  parameter int MODULUS  = 16,
  parameter int PRESCALE = 100000000
) (
  input  logic               CLK,
  input  logic               rst,
  input  logic               CLR,
  input  logic               EN,
  input  logic               DIR,
  input  logic               MODE,
  input  logic               PE,
  input  logic [WIDTH-1:0]   D,
  output logic [WIDTH-1:0]   Q,
  output logic [MODULUS-1:0] LED,
  output logic               TICK,
  output logic               TC
);

  localparam int                PW      = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0]     PC_MAX  = PW'(PRESCALE - 1);
  localparam logic [WIDTH-1:0]  Q_MAX   = WIDTH'(MODULUS - 1);
  localparam logic [WIDTH:0]    MOD_EXT = (WIDTH + 1)'(MODULUS);

  logic [PW-1:0]    pc;
  logic [WIDTH-1:0] q_n;
  logic             at_term;

  // Gated by rst so a reset holds TICK low even when PRESCALE is 1.
  assign TICK    = ~rst & (pc == PC_MAX);
  assign at_term = DIR ? (Q == Q_MAX) : (Q == '0);
  assign TC      = TICK & EN & ~CLR & ~PE & at_term;

  always_comb begin
    q_n = Q;
    if (CLR) begin
      q_n = '0;
    end else if (PE) begin
      q_n = ({1'b0, D} >= MOD_EXT) ? Q_MAX : D;
    end else if (TICK & EN) begin
      if (DIR) begin
        q_n = (Q != Q_MAX) ? Q + 1'b1 : (MODE ? Q : '0);
      end else begin
        q_n = (Q != '0) ? Q - 1'b1 : (MODE ? Q : Q_MAX);
      end
    end
  end

  always_ff @(posedge CLK or posedge rst) begin
    if (rst) begin
      Q   <= '0;
      LED <= MODULUS'(1);
      pc  <= '0;
    end else begin
      Q   <= q_n;
      LED <= MODULUS'(1) << q_n;
      pc  <= (CLR || pc == PC_MAX) ? '0 : pc + 1'b1;
    end
  end

endmodule

// File: tb/tb_mod_n_updown_counter.sv
// Bench for mod_n_updown_counter: MODULUS=10, PRESCALE=4 main instance plus a PRESCALE=1 instance.
module tb_mod_n_updown_counter;

  logic       CLK, rst, CLR, EN, DIR, MODE, PE;
  logic [3:0] D;
  logic [3:0] Q, q1;
  logic [9:0] LED, led1;
  logic       TICK, TC, tick1, tc1;

  mod_n_updown_counter #(.WIDTH(4), .MODULUS(10), .PRESCALE(4)) dut (
    .CLK(CLK), .rst(rst), .CLR(CLR), .EN(EN), .DIR(DIR), .MODE(MODE), .PE(PE),
    .D(D), .Q(Q), .LED(LED), .TICK(TICK), .TC(TC)
  );

  mod_n_updown_counter #(.WIDTH(4), .MODULUS(10), .PRESCALE(1)) dut1 (
    .CLK(CLK), .rst(rst), .CLR(CLR), .EN(EN), .DIR(DIR), .MODE(MODE), .PE(PE),
    .D(D), .Q(q1), .LED(led1), .TICK(tick1), .TC(tc1)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    logic       clr, pe, en, dir, mode;
    logic [3:0] d;
    int         ncyc;
    logic [3:0] exp_q;
  } vec_t;

  vec_t       vecs[20];
  int         n_chk, n_fail;
  logic [3:0] sb_q[$];
  int         mq, mpc;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock: drive at negedge, check combinational outputs, queue expected Q, compare after posedge.
  task automatic cycle(input logic clr, input logic pe, input logic en, input logic dir,
                       input logic mode, input logic [3:0] d);
    logic       mtick, mtc;
    logic [3:0] eq;
    @(negedge CLK);
    CLR = clr; PE = pe; EN = en; DIR = dir; MODE = mode; D = d;
    #1;
    mtick = (mpc == 3);
    mtc   = mtick & en & ~clr & ~pe & (dir ? (mq == 9) : (mq == 0));
    check("tick", 32'(TICK), 32'(mtick));
    check("tc", 32'(TC), 32'(mtc));
    if (clr) begin
      mq = 0; mpc = 0;
    end else begin
      if (pe) mq = (d >= 10) ? 9 : int'(d);
      else if (mtick && en) begin
        if (dir) mq = (mq < 9) ? mq + 1 : (mode ? mq : 0);
        else     mq = (mq > 0) ? mq - 1 : (mode ? mq : 9);
      end
      mpc = (mpc == 3) ? 0 : mpc + 1;
    end
    sb_q.push_back(4'(mq));
    @(posedge CLK);
    #1;
    eq = sb_q.pop_front();
    check("q", 32'(Q), 32'(eq));
    check("led", 32'(LED), 32'(10'(1) << eq));
  endtask

  initial begin
    n_chk = 0; n_fail = 0;
    rst = 1'b1; CLR = 0; PE = 0; EN = 0; DIR = 0; MODE = 0; D = '0;
    // clr pe en dir mode d ncyc exp_q
    vecs[0]  = '{0, 0, 1, 1, 0, 4'd0, 4, 4'd1};
    vecs[1]  = '{0, 0, 1, 1, 0, 4'd0, 32, 4'd9};
    vecs[2]  = '{0, 0, 1, 1, 0, 4'd0, 4, 4'd0};
    vecs[3]  = '{0, 0, 1, 0, 0, 4'd0, 4, 4'd9};
    vecs[4]  = '{0, 0, 1, 0, 0, 4'd0, 8, 4'd7};
    vecs[5]  = '{0, 0, 1, 1, 1, 4'd0, 8, 4'd9};
    vecs[6]  = '{0, 0, 1, 1, 1, 4'd0, 8, 4'd9};
    vecs[7]  = '{0, 0, 1, 0, 1, 4'd0, 4, 4'd8};
    vecs[8]  = '{0, 0, 1, 0, 1, 4'd0, 32, 4'd0};
    vecs[9]  = '{0, 0, 1, 0, 1, 4'd0, 4, 4'd0};
    vecs[10] = '{0, 0, 0, 1, 0, 4'd0, 8, 4'd0};
    vecs[11] = '{0, 1, 1, 1, 0, 4'd13, 1, 4'd9};
    vecs[12] = '{0, 1, 1, 1, 0, 4'd5, 1, 4'd5};
    vecs[13] = '{0, 1, 1, 1, 0, 4'd9, 1, 4'd9};
    vecs[14] = '{0, 1, 1, 1, 0, 4'd2, 1, 4'd2};
    vecs[15] = '{0, 0, 0, 1, 0, 4'd0, 3, 4'd2};
    vecs[16] = '{1, 1, 1, 1, 0, 4'd7, 1, 4'd0};
    vecs[17] = '{0, 0, 1, 1, 0, 4'd0, 3, 4'd0};
    vecs[18] = '{0, 0, 1, 1, 0, 4'd0, 1, 4'd1};
    vecs[19] = '{0, 0, 1, 1, 0, 4'd0, 7, 4'd2};

    #2;
    check("rst_q", 32'(Q), 32'd0);
    check("rst_led", 32'(LED), 32'd1);
    check("rst_tick", 32'(TICK), 32'd0);
    check("rst_tc", 32'(TC), 32'd0);
    check("rst_tick1", 32'(tick1), 32'd0);
    @(posedge CLK);
    #2 rst = 1'b0;
    mq = 0; mpc = 0;

    for (int i = 0; i < 20; i++) begin
      for (int c = 0; c < vecs[i].ncyc; c++)
        cycle(vecs[i].clr, vecs[i].pe, vecs[i].en, vecs[i].dir, vecs[i].mode, vecs[i].d);
      check($sformatf("vec%0d_q", i), 32'(Q), 32'(vecs[i].exp_q));
    end

    // Asynchronous reset between edges while a tick is pending.
    #2;
    check("pre_rst_tick", 32'(TICK), 32'd1);
    rst = 1'b1;
    #1;
    check("arst_q", 32'(Q), 32'd0);
    check("arst_led", 32'(LED), 32'd1);
    check("arst_tick", 32'(TICK), 32'd0);
    check("arst_tc", 32'(TC), 32'd0);
    @(posedge CLK);
    #2 rst = 1'b0;
    mq = 0; mpc = 0;

    // Resume counting; the PRESCALE=1 instance steps on every edge.
    for (int k = 1; k <= 4; k++) begin
      cycle(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 4'd0);
      check($sformatf("p1_q%0d", k), 32'(q1), 32'(k));
      check($sformatf("p1_led%0d", k), 32'(led1), 32'(10'(1) << k));
      check("p1_tick", 32'(tick1), 32'd1);
      check("p1_tc", 32'(tc1), 32'd0);
    end
    check("resume_q", 32'(Q), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
